// File: rtl/core_uart_pkg.sv
// core_uart_pkg: register map, status bit positions, parity codes and frame states shared by the UART
package core_uart_pkg;
  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;
  localparam logic [4:0] ADDR_CTRL3  = 5'h14;
  localparam int ST_TXRDY = 0;
  localparam int ST_RXRDY = 1;
  localparam int ST_PARITY = 2;
  localparam int ST_OVERFLOW = 3;
  localparam int ST_FRAMING = 4;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;
  function automatic logic frame_parity(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
endpackage

// File: rtl/core_uart_baud_gen.sv
// core_uart_baud_gen: 16x oversampling tick from a 13-bit divisor with optional 1/8 fractional stretch
module core_uart_baud_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] divisor,
  input  logic [2:0]  frctn,
  input  logic        frctn_en,
  output logic        tick
);
  logic [12:0] cnt_q, cnt_d;
  logic [2:0] acc_q, acc_d;
  logic stretch_q, stretch_d, term;
  logic [3:0] sum;
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, frctn};
    term = cnt_q >= divisor;
    tick = term && !stretch_q;
    cnt_d = term ? (stretch_q ? cnt_q : 13'd0) : cnt_q + 13'd1;
    acc_d = tick && frctn_en ? sum[2:0] : acc_q;
    stretch_d = term ? (!stretch_q && frctn_en && sum[3]) : stretch_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      stretch_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      stretch_q <= stretch_d;
    end
  end
endmodule

// File: rtl/core_uart_apb.sv
// core_uart_apb: zero-wait APB3 UART with single TX/RX holding registers and programmable framing
module core_uart_apb
  import core_uart_pkg::*;
#(
  parameter int FAMILY = 17,
  parameter int TX_FIFO = 0,
  parameter int RX_FIFO = 0,
  parameter int FIXEDMODE = 0,
  parameter int BAUD_VALUE = 1,
  parameter int PRG_BIT8 = 0,
  parameter int PRG_PARITY = 0,
  parameter int RX_LEGACY_MODE = 0,
  parameter int BAUD_VAL_FRCTN = 0,
  parameter int BAUD_VAL_FRCTN_EN = 0
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [4:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic       TXRDY,
  output logic       RXRDY,
  output logic       PARITY_ERR,
  output logic       FRAMING_ERR,
  output logic       OVERFLOW,
  input  logic       RX,
  output logic       TX
);
  localparam bit LEGACY = RX_LEGACY_MODE != 0;
  logic wr, rd_rx, tick, stop_hit, done, c_perr, c_ferr;
  logic [7:0] status;
  logic [12:0] baud_q, baud_d;
  logic [2:0] frctn_q, frctn_d;
  logic bit8_q, bit8_d, par_en_q, par_en_d, odd_q, odd_d;
  logic [7:0] hold_q, hold_d, tx_sh_q, tx_sh_d;
  logic txrdy_q, txrdy_d, tx_q, tx_d, tx_par_q, tx_par_d, tx_b8_q, tx_b8_d, tx_pen_q, tx_pen_d;
  uart_state_e tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [3:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, pcnt_q, pcnt_d;
  logic [2:0] tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic [7:0] rx_sh_q, rx_sh_d, rx_data, pdat_q, pdat_d, rxdata_q, rxdata_d, c_data;
  logic rx_b8_q, rx_b8_d, rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
  logic pend_q, pend_d, pperr_q, pperr_d, pferr_q, pferr_d;
  logic rxrdy_q, rxrdy_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  core_uart_baud_gen u_baud (
    .clk(PCLK), .rst_n(PRESETN), .divisor(baud_q), .frctn(frctn_q),
    .frctn_en(BAUD_VAL_FRCTN_EN != 0), .tick(tick)
  );
  always_comb begin
    wr = PSEL & PENABLE & PWRITE;
    rd_rx = PSEL & PENABLE & ~PWRITE & (PADDR == ADDR_RXDATA);
    baud_d = baud_q;
    frctn_d = frctn_q;
    {odd_d, par_en_d, bit8_d} = {odd_q, par_en_q, bit8_q};
    if (wr && FIXEDMODE == 0) begin
      if (PADDR == ADDR_CTRL1) baud_d[7:0] = PWDATA;
      if (PADDR == ADDR_CTRL2) {baud_d[12:8], odd_d, par_en_d, bit8_d} = PWDATA;
      if (PADDR == ADDR_CTRL3) frctn_d = PWDATA[2:0];
    end
    status = '0;
    status[ST_TXRDY] = txrdy_q;
    status[ST_RXRDY] = rxrdy_q;
    status[ST_PARITY] = perr_q;
    status[ST_OVERFLOW] = ovf_q;
    status[ST_FRAMING] = ferr_q;
    PRDATA = PADDR == ADDR_RXDATA ? rxdata_q :
             PADDR == ADDR_CTRL1 ? baud_q[7:0] :
             PADDR == ADDR_CTRL2 ? {baud_q[12:8], odd_q, par_en_q, bit8_q} :
             PADDR == ADDR_STATUS ? status :
             PADDR == ADDR_CTRL3 ? {5'b0, frctn_q} : 8'h00;
  end
  // Framing options are captured at frame start so mid-frame control writes only affect the next frame.
  always_comb begin
    tx_st_d = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_idx_d = tx_idx_q;
    tx_sh_d = tx_sh_q;
    tx_par_d = tx_par_q;
    tx_b8_d = tx_b8_q;
    tx_pen_d = tx_pen_q;
    hold_d = hold_q;
    txrdy_d = txrdy_q;
    if (wr && PADDR == ADDR_TXDATA && txrdy_q) begin
      hold_d = PWDATA;
      txrdy_d = 1'b0;
    end
    if (tick) begin
      tx_cnt_d = tx_cnt_q + 4'd1;
      if (tx_st_q == S_IDLE) begin
        if (!txrdy_q) begin
          tx_st_d = S_START;
          tx_cnt_d = '0;
          tx_idx_d = '0;
          txrdy_d = 1'b1;
          tx_sh_d = bit8_q ? hold_q : {1'b0, hold_q[6:0]};
          tx_par_d = frame_parity(tx_sh_d, odd_q);
          tx_b8_d = bit8_q;
          tx_pen_d = par_en_q;
        end
      end else if (tx_cnt_q == 4'd15) begin
        case (tx_st_q)
          S_START: tx_st_d = S_DATA;
          S_DATA: begin
            tx_idx_d = tx_idx_q + 3'd1;
            if (tx_idx_q == (tx_b8_q ? 3'd7 : 3'd6)) tx_st_d = tx_pen_q ? S_PARITY : S_STOP;
            else tx_sh_d = tx_sh_q >> 1;
          end
          S_PARITY: tx_st_d = S_STOP;
          default: tx_st_d = S_IDLE;
        endcase
      end
    end
    tx_d = tx_st_d == S_START ? 1'b0 : tx_st_d == S_DATA ? tx_sh_d[0] :
           tx_st_d == S_PARITY ? tx_par_d : 1'b1;
  end
  // START checks at tick 8; every later sample is 16 ticks on, i.e. mid-bit.
  always_comb begin
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_idx_d = rx_idx_q;
    rx_sh_d = rx_sh_q;
    rx_b8_d = rx_b8_q;
    rx_pen_d = rx_pen_q;
    rx_odd_d = rx_odd_q;
    rx_perr_d = rx_perr_q;
    rx_data = rx_b8_q ? rx_sh_q : {1'b0, rx_sh_q[7:1]};
    stop_hit = 1'b0;
    if (rx_st_q == S_IDLE) begin
      if (rx_prev_q && !rx_s2_q) begin
        rx_st_d = S_START;
        rx_cnt_d = '0;
        rx_b8_d = bit8_q;
        rx_pen_d = par_en_q;
        rx_odd_d = odd_q;
      end
    end else if (tick) begin
      rx_cnt_d = rx_cnt_q + 4'd1;
      if (rx_cnt_q == (rx_st_q == S_START ? 4'd7 : 4'd15)) begin
        rx_cnt_d = '0;
        case (rx_st_q)
          S_START: begin
            rx_st_d = rx_s2_q ? S_IDLE : S_DATA;
            rx_idx_d = '0;
            rx_perr_d = 1'b0;
          end
          S_DATA: begin
            rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
            rx_idx_d = rx_idx_q + 3'd1;
            if (rx_idx_q == (rx_b8_q ? 3'd7 : 3'd6)) rx_st_d = rx_pen_q ? S_PARITY : S_STOP;
          end
          S_PARITY: begin
            rx_perr_d = rx_s2_q != frame_parity(rx_data, rx_odd_q);
            rx_st_d = S_STOP;
          end
          default: begin
            rx_st_d = S_IDLE;
            stop_hit = 1'b1;
          end
        endcase
      end
    end
  end
  // Legacy mode parks the finished frame for one more bit-time while the FSM is already free to hunt.
  always_comb begin
    pend_d = pend_q;
    pcnt_d = pend_q && tick ? pcnt_q + 4'd1 : pcnt_q;
    pdat_d = pdat_q;
    pperr_d = pperr_q;
    pferr_d = pferr_q;
    done = LEGACY ? pend_q && tick && pcnt_q == 4'd15 : stop_hit;
    c_data = LEGACY ? pdat_q : rx_data;
    c_perr = LEGACY ? pperr_q : rx_perr_q;
    c_ferr = LEGACY ? pferr_q : !rx_s2_q;
    if (done) pend_d = 1'b0;
    if (LEGACY && stop_hit) begin
      pend_d = 1'b1;
      pcnt_d = '0;
      pdat_d = rx_data;
      pperr_d = rx_perr_q;
      pferr_d = !rx_s2_q;
    end
    rxrdy_d = rxrdy_q & ~rd_rx;
    perr_d = perr_q & ~rd_rx;
    ferr_d = ferr_q & ~rd_rx;
    ovf_d = ovf_q & ~rd_rx;
    rxdata_d = rxdata_q;
    if (done) begin
      rxrdy_d = 1'b1;
      ovf_d = ovf_d | (rxrdy_q & ~rd_rx);
      perr_d = perr_d | c_perr;
      ferr_d = ferr_d | c_ferr;
      if (!rxrdy_q || rd_rx) rxdata_d = c_data;
    end
  end
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      baud_q <= 13'(BAUD_VALUE);
      frctn_q <= 3'(BAUD_VAL_FRCTN);
      bit8_q <= PRG_BIT8 != 0;
      par_en_q <= 2'(PRG_PARITY) != PAR_NONE;
      odd_q <= 2'(PRG_PARITY) == PAR_ODD;
      hold_q <= '0;
      tx_sh_q <= '0;
      txrdy_q <= 1'b1;
      tx_q <= 1'b1;
      tx_par_q <= 1'b0;
      tx_b8_q <= 1'b0;
      tx_pen_q <= 1'b0;
      tx_st_q <= S_IDLE;
      tx_cnt_q <= '0;
      tx_idx_q <= '0;
      rx_st_q <= S_IDLE;
      rx_cnt_q <= '0;
      rx_idx_q <= '0;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_sh_q <= '0;
      rx_b8_q <= 1'b0;
      rx_pen_q <= 1'b0;
      rx_odd_q <= 1'b0;
      rx_perr_q <= 1'b0;
      pend_q <= 1'b0;
      pcnt_q <= '0;
      pdat_q <= '0;
      pperr_q <= 1'b0;
      pferr_q <= 1'b0;
      rxdata_q <= '0;
      rxrdy_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      baud_q <= baud_d;
      frctn_q <= frctn_d;
      bit8_q <= bit8_d;
      par_en_q <= par_en_d;
      odd_q <= odd_d;
      hold_q <= hold_d;
      tx_sh_q <= tx_sh_d;
      txrdy_q <= txrdy_d;
      tx_q <= tx_d;
      tx_par_q <= tx_par_d;
      tx_b8_q <= tx_b8_d;
      tx_pen_q <= tx_pen_d;
      tx_st_q <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_idx_q <= tx_idx_d;
      rx_st_q <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_idx_q <= rx_idx_d;
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_sh_q <= rx_sh_d;
      rx_b8_q <= rx_b8_d;
      rx_pen_q <= rx_pen_d;
      rx_odd_q <= rx_odd_d;
      rx_perr_q <= rx_perr_d;
      pend_q <= pend_d;
      pcnt_q <= pcnt_d;
      pdat_q <= pdat_d;
      pperr_q <= pperr_d;
      pferr_q <= pferr_d;
      rxdata_q <= rxdata_d;
      rxrdy_q <= rxrdy_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovf_q <= ovf_d;
    end
  end
  assign PREADY = 1'b1;
  assign PSLVERR = 1'b0;
  assign TX = tx_q;
  assign TXRDY = txrdy_q;
  assign RXRDY = rxrdy_q;
  assign PARITY_ERR = perr_q;
  assign FRAMING_ERR = ferr_q;
  assign OVERFLOW = ovf_q;
endmodule

// File: tb/tb_core_uart_apb.sv
// tb_core_uart_apb: two UARTs wired TX1->RX2, random frames checked against a bit-level frame model
module tb_core_uart_apb;
  import core_uart_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, psel1, psel2, penable, pwrite;
  logic [4:0] paddr;
  logic [7:0] pwdata, prdata1, prdata2;
  logic pready1, pready2, pslverr1, pslverr2;
  logic txrdy1, rxrdy1, perr1, ferr1, ovf1, tx1;
  logic txrdy2, rxrdy2, perr2, ferr2, ovf2, tx2;
  logic rx2_force, rx2_val, rx2;
  int n_cmp = 0, n_bad = 0;
  assign rx2 = rx2_force ? rx2_val : tx1;
  core_uart_apb #(.BAUD_VALUE(1), .PRG_BIT8(1), .BAUD_VAL_FRCTN_EN(1)) u1 (
    .PCLK(clk), .PRESETN(rst_n), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1),
    .TXRDY(txrdy1), .RXRDY(rxrdy1), .PARITY_ERR(perr1), .FRAMING_ERR(ferr1),
    .OVERFLOW(ovf1), .RX(tx2), .TX(tx1));
  core_uart_apb #(.BAUD_VALUE(1), .PRG_BIT8(1), .BAUD_VAL_FRCTN_EN(1)) u2 (
    .PCLK(clk), .PRESETN(rst_n), .PSEL(psel2), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2),
    .TXRDY(txrdy2), .RXRDY(rxrdy2), .PARITY_ERR(perr2), .FRAMING_ERR(ferr2),
    .OVERFLOW(ovf2), .RX(rx2), .TX(tx2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic apb_wr(input int u, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    psel1 = u == 1; psel2 = u == 2; paddr = a; pwdata = d; pwrite = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel1 = 1'b0; psel2 = 1'b0; penable = 1'b0;
  endtask
  task automatic apb_rd(input int u, input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    psel1 = u == 1; psel2 = u == 2; paddr = a; pwrite = 1'b0; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 d = u == 1 ? prdata1 : prdata2;
    @(negedge clk);
    psel1 = 1'b0; psel2 = 1'b0; penable = 1'b0;
  endtask
  task automatic cfg(input int u, input logic b8, input int par);
    apb_wr(u, ADDR_CTRL2, {5'b0, par == 2, par != 0, b8});
  endtask
  task automatic wait_flag(input string tag, input int which);
    logic f;
    f = 1'b0;
    for (int i = 0; i < 3000 && !f; i++) begin
      @(negedge clk);
      f = which == 0 ? rxrdy2 : which == 1 ? ovf2 : ferr2;
    end
    check(tag, f, 1);
  endtask
  // Builds the line as a list of bit periods and lets the receiver read it with its own framing.
  function automatic void model(input logic [7:0] b, input logic b8, input int tp, input int rp,
                                output logic [7:0] d, output logic pe, output logic fe);
    logic line [0:11];
    int n;
    logic [7:0] td;
    n = b8 ? 8 : 7;
    td = b8 ? b : (b & 8'h7F);
    for (int i = 0; i < 12; i++) line[i] = 1'b1;
    line[0] = 1'b0;
    for (int i = 0; i < n; i++) line[1 + i] = b[i];
    if (tp != 0) line[1 + n] = (($countones(td) % 2) == 1) ^ (tp == 2);
    d = '0;
    for (int i = 0; i < n; i++) d[i] = line[1 + i];
    pe = rp != 0 && line[1 + n] != ((($countones(d) % 2) == 1) ^ (rp == 2));
    fe = !line[rp != 0 ? 2 + n : 1 + n];
  endfunction
  task automatic xfer(input logic [7:0] b, input logic b8, input int tp, input int rp);
    logic [7:0] ed, s, d;
    logic pe, fe;
    cfg(1, b8, tp);
    cfg(2, b8, rp);
    model(b, b8, tp, rp, ed, pe, fe);
    apb_wr(1, ADDR_TXDATA, b);
    check("txrdy_busy", txrdy1, 0);
    wait_flag("rx_done", 0);
    apb_rd(2, ADDR_STATUS, s);
    check("rx_status", s, {3'b0, fe, 1'b0, pe, 1'b1, 1'b1});
    apb_rd(2, ADDR_RXDATA, d);
    check("rx_data", d, ed);
    apb_rd(2, ADDR_STATUS, s);
    check("status_clr", s, 8'h01);
    repeat (100) @(negedge clk);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [7:0] s, d;
    int w;
    rst_n = 1'b0; psel1 = 0; psel2 = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    rx2_force = 1'b0; rx2_val = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", tx1, 1);
    rst_n = 1'b1;
    apb_rd(1, ADDR_STATUS, s);
    check("reset_status", s, 8'h01);
    apb_rd(2, ADDR_RXDATA, d);
    check("reset_rxdata", d, 8'h00);
    apb_rd(1, ADDR_CTRL2, d);
    check("reset_ctrl2", d, 8'h01);
    check("pready_pslverr", {pready1, pslverr1}, 2'b10);
    xfer(8'h55, 1'b1, 0, 0);
    check("rxrdy_pin_clr", rxrdy2, 0);
    xfer(8'hA3, 1'b1, 2, 1);
    cfg(2, 1'b1, 0);
    rx2_force = 1'b1; rx2_val = 1'b0;
    wait_flag("framing_wait", 2);
    apb_rd(2, ADDR_STATUS, s);
    check("framing_status", s, 8'h13);
    apb_rd(2, ADDR_RXDATA, d);
    check("framing_rxdata", d, 8'h00);
    rx2_force = 1'b0;
    apb_rd(2, ADDR_STATUS, s);
    check("framing_clr", s, 8'h01);
    cfg(1, 1'b1, 0);
    apb_wr(1, ADDR_TXDATA, 8'h11);
    wait_flag("ovf_first", 0);
    repeat (100) @(negedge clk);
    apb_wr(1, ADDR_TXDATA, 8'h22);
    wait_flag("ovf_wait", 1);
    apb_rd(2, ADDR_STATUS, s);
    check("ovf_status", s, 8'h0B);
    apb_rd(2, ADDR_RXDATA, d);
    check("ovf_rxdata", d, 8'h11);
    apb_rd(2, ADDR_STATUS, s);
    check("ovf_clr", s, 8'h01);
    repeat (100) @(negedge clk);
    for (int k = 0; k < 8; k++)
      xfer(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    apb_wr(1, ADDR_CTRL3, 8'h04);
    apb_wr(2, ADDR_CTRL3, 8'h04);
    cfg(1, 1'b0, 0);
    cfg(2, 1'b0, 0);
    apb_wr(1, ADDR_TXDATA, 8'hFF);
    w = 0;
    while (tx1 !== 1'b0 && w < 500) begin
      w++;
      @(negedge clk);
    end
    check("start_seen", tx1, 0);
    w = 0;
    while (tx1 === 1'b0 && w < 200) begin
      w++;
      @(negedge clk);
    end
    check("frac_bit_len", w, 40);
    wait_flag("frac_rx", 0);
    apb_rd(2, ADDR_RXDATA, d);
    check("frac_rxdata_7bit", d, 8'h7F);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
